// File: rtl/axi_burst_master.sv
// axi_burst_master: single-outstanding AXI4 INCR burst master bridging a simple
// command port and write/read data streams onto AW/W/B/AR/R channels.
// Optional feature: define AXI_BURST_MASTER_4K_CHECK_EN to reject bursts that
// would cross a 4 KB boundary (done with err=1, no AXI traffic).
module axi_burst_master #(
    parameter int unsigned AXI_ID_WIDTH   = 1,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_USER_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        reset,

    // command port
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]                  cmd_len,

    // write-data source stream
    input  logic [AXI_DATA_WIDTH-1:0]   wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,

    // read-data sink stream
    output logic [AXI_DATA_WIDTH-1:0]   rd_data,
    output logic                        rd_last,
    output logic                        rd_valid,
    input  logic                        rd_ready,

    // completion
    output logic                        done,
    output logic                        err,

    // AW channel
    output logic [AXI_ID_WIDTH-1:0]     AXI_master_awid,
    output logic [AXI_ADDR_WIDTH-1:0]   AXI_master_awaddr,
    output logic [7:0]                  AXI_master_awlen,
    output logic [2:0]                  AXI_master_awsize,
    output logic [1:0]                  AXI_master_awburst,
    output logic                        AXI_master_awlock,
    output logic [3:0]                  AXI_master_awcache,
    output logic [2:0]                  AXI_master_awprot,
    output logic [3:0]                  AXI_master_awqos,
    output logic [3:0]                  AXI_master_awregion,
    output logic [AXI_USER_WIDTH-1:0]   AXI_master_awuser,
    output logic                        AXI_master_awvalid,
    input  logic                        AXI_master_awready,

    // W channel
    output logic [AXI_ID_WIDTH-1:0]     AXI_master_wid,
    output logic [AXI_DATA_WIDTH-1:0]   AXI_master_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] AXI_master_wstrb,
    output logic                        AXI_master_wlast,
    output logic [AXI_USER_WIDTH-1:0]   AXI_master_wuser,
    output logic                        AXI_master_wvalid,
    input  logic                        AXI_master_wready,

    // B channel
    input  logic [AXI_ID_WIDTH-1:0]     AXI_master_bid,
    input  logic [1:0]                  AXI_master_bresp,
    input  logic [AXI_USER_WIDTH-1:0]   AXI_master_buser,
    input  logic                        AXI_master_bvalid,
    output logic                        AXI_master_bready,

    // AR channel
    output logic [AXI_ID_WIDTH-1:0]     AXI_master_arid,
    output logic [AXI_ADDR_WIDTH-1:0]   AXI_master_araddr,
    output logic [7:0]                  AXI_master_arlen,
    output logic [2:0]                  AXI_master_arsize,
    output logic [1:0]                  AXI_master_arburst,
    output logic                        AXI_master_arlock,
    output logic [3:0]                  AXI_master_arcache,
    output logic [2:0]                  AXI_master_arprot,
    output logic [3:0]                  AXI_master_arqos,
    output logic [3:0]                  AXI_master_arregion,
    output logic [AXI_USER_WIDTH-1:0]   AXI_master_aruser,
    output logic                        AXI_master_arvalid,
    input  logic                        AXI_master_arready,

    // R channel
    input  logic [AXI_ID_WIDTH-1:0]     AXI_master_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   AXI_master_rdata,
    input  logic [1:0]                  AXI_master_rresp,
    input  logic                        AXI_master_rlast,
    input  logic [AXI_USER_WIDTH-1:0]   AXI_master_ruser,
    input  logic                        AXI_master_rvalid,
    output logic                        AXI_master_rready
);

    localparam int unsigned STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_VAL = $clog2(STRB_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_e;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [7:0]                len_q,   len_d;
    logic                      write_q, write_d;
    logic [7:0]                beat_cnt_q, beat_cnt_d;
    logic                      rerr_q,  rerr_d;
    logic                      done_q,  done_d;
    logic                      err_q,   err_d;

    logic [7:0]                beat_inc;
    logic                      last_beat;
    logic                      r_beat_err;
    logic                      crosses_4k;
    logic                      unused_inputs;

    // Response IDs and user fields are not needed with a single command in flight.
    assign unused_inputs = ^{AXI_master_bid, AXI_master_buser,
                             AXI_master_rid, AXI_master_ruser};

`ifdef AXI_BURST_MASTER_4K_CHECK_EN
    logic [31:0] burst_end;

    // Byte offset one past the burst, relative to the start of its 4 KB page.
    assign burst_end  = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) << SIZE_VAL);
    assign crosses_4k = (burst_end > 32'd4096);
`else
    assign crosses_4k = 1'b0;
`endif

    // Saturating beat counter step and last-beat compare.
    assign beat_inc   = (beat_cnt_q == 8'hFF) ? beat_cnt_q : beat_cnt_q + 8'd1;
    assign last_beat  = (beat_cnt_q == len_q);
    assign r_beat_err = (AXI_master_rresp != 2'b00);

    // Constant AXI attributes and latched command fields.
    assign AXI_master_awid     = '0;
    assign AXI_master_awaddr   = addr_q;
    assign AXI_master_awlen    = len_q;
    assign AXI_master_awsize   = 3'(SIZE_VAL);
    assign AXI_master_awburst  = 2'b01;
    assign AXI_master_awlock   = 1'b0;
    assign AXI_master_awcache  = 4'd0;
    assign AXI_master_awprot   = 3'd0;
    assign AXI_master_awqos    = 4'd0;
    assign AXI_master_awregion = 4'd0;
    assign AXI_master_awuser   = '0;

    assign AXI_master_wid      = AXI_master_awid;
    assign AXI_master_wdata    = wr_data;
    assign AXI_master_wstrb    = '1;
    assign AXI_master_wuser    = '0;
    assign AXI_master_wlast    = (state_q == S_W) && last_beat;

    assign AXI_master_arid     = '0;
    assign AXI_master_araddr   = addr_q;
    assign AXI_master_arlen    = len_q;
    assign AXI_master_arsize   = 3'(SIZE_VAL);
    assign AXI_master_arburst  = 2'b01;
    assign AXI_master_arlock   = 1'b0;
    assign AXI_master_arcache  = 4'd0;
    assign AXI_master_arprot   = 3'd0;
    assign AXI_master_arqos    = 4'd0;
    assign AXI_master_arregion = 4'd0;
    assign AXI_master_aruser   = '0;

    assign rd_data = AXI_master_rdata;
    assign done    = done_q;
    assign err     = err_q;

    // Next-state, datapath updates and channel handshakes.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        write_d    = write_q;
        beat_cnt_d = beat_cnt_q;
        rerr_d     = rerr_q;
        done_d     = 1'b0;
        err_d      = err_q;

        cmd_ready          = 1'b0;
        wr_ready           = 1'b0;
        rd_valid           = 1'b0;
        rd_last            = 1'b0;
        AXI_master_awvalid = 1'b0;
        AXI_master_wvalid  = 1'b0;
        AXI_master_bready  = 1'b0;
        AXI_master_arvalid = 1'b0;
        AXI_master_rready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Hold off a new command while the completion pulse is visible.
                cmd_ready = !done_q && !reset;
                if (cmd_valid && cmd_ready) begin
                    addr_d     = cmd_addr;
                    len_d      = cmd_len;
                    write_d    = cmd_write;
                    beat_cnt_d = 8'd0;
                    if (crosses_4k) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end

            S_AW: begin
                AXI_master_awvalid = 1'b1;
                if (AXI_master_awready) begin
                    beat_cnt_d = 8'd0;
                    state_d    = S_W;
                end
            end

            S_W: begin
                AXI_master_wvalid = wr_valid;
                wr_ready          = AXI_master_wready;
                if (wr_valid && AXI_master_wready) begin
                    if (last_beat) begin
                        state_d = S_B;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end

            S_B: begin
                AXI_master_bready = 1'b1;
                if (AXI_master_bvalid) begin
                    err_d   = (AXI_master_bresp != 2'b00);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            S_AR: begin
                AXI_master_arvalid = 1'b1;
                if (AXI_master_arready) begin
                    beat_cnt_d = 8'd0;
                    rerr_d     = 1'b0;
                    state_d    = S_R;
                end
            end

            S_R: begin
                rd_valid          = AXI_master_rvalid;
                rd_last           = AXI_master_rlast;
                AXI_master_rready = rd_ready;
                if (AXI_master_rvalid && rd_ready) begin
                    if (AXI_master_rlast) begin
                        // An rlast that arrives before the expected beat count is an error.
                        err_d   = rerr_q || r_beat_err || !last_beat;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Beats beyond len without rlast are also flagged.
                        rerr_d     = rerr_q || r_beat_err || last_beat;
                        beat_cnt_d = beat_inc;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= 8'd0;
            write_q    <= 1'b0;
            beat_cnt_q <= 8'd0;
            rerr_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            write_q    <= write_d;
            beat_cnt_q <= beat_cnt_d;
            rerr_q     <= rerr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: table-driven bench for axi_burst_master with a small
// bench-side AXI slave and stream source/sink; plus hand-written reset sequences.
`timescale 1ns/1ps
module tb_axi_burst_master;

    localparam int unsigned IDW  = 1;
    localparam int unsigned DW   = 32;
    localparam int unsigned ADW  = 32;
    localparam int unsigned UW   = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic           cmd_valid, cmd_ready, cmd_write;
    logic [ADW-1:0] cmd_addr;
    logic [7:0]     cmd_len;
    logic [DW-1:0]  wr_data;
    logic           wr_valid, wr_ready;
    logic [DW-1:0]  rd_data;
    logic           rd_last, rd_valid, rd_ready;
    logic           done, err;

    logic [IDW-1:0] awid;   logic [ADW-1:0] awaddr; logic [7:0] awlen; logic [2:0] awsize;
    logic [1:0]     awburst; logic awlock; logic [3:0] awcache; logic [2:0] awprot;
    logic [3:0]     awqos;  logic [3:0] awregion; logic [UW-1:0] awuser; logic awvalid, awready;
    logic [IDW-1:0] wid;    logic [DW-1:0] wdata;   logic [DW/8-1:0] wstrb; logic wlast;
    logic [UW-1:0]  wuser;  logic wvalid, wready;
    logic [IDW-1:0] bid;    logic [1:0] bresp;      logic [UW-1:0] buser; logic bvalid, bready;
    logic [IDW-1:0] arid;   logic [ADW-1:0] araddr; logic [7:0] arlen; logic [2:0] arsize;
    logic [1:0]     arburst; logic arlock; logic [3:0] arcache; logic [2:0] arprot;
    logic [3:0]     arqos;  logic [3:0] arregion; logic [UW-1:0] aruser; logic arvalid, arready;
    logic [IDW-1:0] rid;    logic [DW-1:0] rdata;   logic [1:0] rresp; logic rlast;
    logic [UW-1:0]  ruser;  logic rvalid, rready;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    axi_burst_master #(
        .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(ADW), .AXI_USER_WIDTH(UW)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .err(err),
        .AXI_master_awid(awid), .AXI_master_awaddr(awaddr), .AXI_master_awlen(awlen),
        .AXI_master_awsize(awsize), .AXI_master_awburst(awburst), .AXI_master_awlock(awlock),
        .AXI_master_awcache(awcache), .AXI_master_awprot(awprot), .AXI_master_awqos(awqos),
        .AXI_master_awregion(awregion), .AXI_master_awuser(awuser),
        .AXI_master_awvalid(awvalid), .AXI_master_awready(awready),
        .AXI_master_wid(wid), .AXI_master_wdata(wdata), .AXI_master_wstrb(wstrb),
        .AXI_master_wlast(wlast), .AXI_master_wuser(wuser),
        .AXI_master_wvalid(wvalid), .AXI_master_wready(wready),
        .AXI_master_bid(bid), .AXI_master_bresp(bresp), .AXI_master_buser(buser),
        .AXI_master_bvalid(bvalid), .AXI_master_bready(bready),
        .AXI_master_arid(arid), .AXI_master_araddr(araddr), .AXI_master_arlen(arlen),
        .AXI_master_arsize(arsize), .AXI_master_arburst(arburst), .AXI_master_arlock(arlock),
        .AXI_master_arcache(arcache), .AXI_master_arprot(arprot), .AXI_master_arqos(arqos),
        .AXI_master_arregion(arregion), .AXI_master_aruser(aruser),
        .AXI_master_arvalid(arvalid), .AXI_master_arready(arready),
        .AXI_master_rid(rid), .AXI_master_rdata(rdata), .AXI_master_rresp(rresp),
        .AXI_master_rlast(rlast), .AXI_master_ruser(ruser),
        .AXI_master_rvalid(rvalid), .AXI_master_rready(rready)
    );

    // One command scenario and its hand-computed outcome.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [7:0]  len;
        int          err_beat;    // read beat index carrying rresp=SLVERR, -1 none
        int          early_last;  // read beat index carrying an early rlast, -1 none
        logic [1:0]  bresp_v;
        int          mode;        // 0 free-flow, 1 rd_ready toggles, 2 wready low 5 cycles, 3 valids every 3rd cycle
        logic        exp_err;
        int          exp_beats;
        int          exp_addr_hs;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = 8'd0;
        wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bid = '0; bresp = 2'b00; buser = '0; bvalid = 1'b0;
        rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; ruser = '0; rvalid = 1'b0;
    endtask

    // Drive one command through the DUT with a bench-side slave and check the outcome.
    task automatic run_vec(input int idx);
        vec_t v;
        int   wbeat, rbeat, aw_hs, ar_hs, done_cnt, w_cyc;
        logic cmd_sent, w_act, r_act, b_pend, got_err, finished;
        logic exp_last;
        v = vecs[idx];
        wbeat = 0; rbeat = 0; aw_hs = 0; ar_hs = 0; done_cnt = 0; w_cyc = 0;
        cmd_sent = 1'b0; w_act = 1'b0; r_act = 1'b0; b_pend = 1'b0;
        got_err = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            cmd_valid = !cmd_sent;
            cmd_write = v.wr;
            cmd_addr  = v.addr;
            cmd_len   = v.len;
            awready   = 1'b1;
            arready   = 1'b1;
            wr_valid  = w_act && ((v.mode == 3) ? (cyc % 3 == 0) : 1'b1);
            wr_data   = 32'(wbeat + 1);
            wready    = (v.mode == 2) ? (w_cyc >= 5) : 1'b1;
            bvalid    = b_pend;
            bresp     = v.bresp_v;
            rvalid    = r_act && ((v.mode == 3) ? (cyc % 3 == 0) : 1'b1);
            rdata     = 32'hA0 + 32'(rbeat);
            rlast     = (rbeat == v.early_last) || (rbeat == int'(v.len));
            rresp     = (rbeat == v.err_beat) ? 2'b10 : 2'b00;
            rd_ready  = (v.mode == 1) ? (cyc % 2 == 1) : 1'b1;
            #1;
            if (w_act) w_cyc++;
            if (v.mode == 2 && w_act && !wready) begin
                check("w_stall_wvalid", wvalid, 1);
                check("w_stall_wdata", wdata, 32'(wbeat + 1));
            end
            if (cmd_valid && cmd_ready) cmd_sent = 1'b1;
            if (awvalid && awready) begin
                aw_hs++;
                check("awaddr", awaddr, v.addr);
                check("awlen", awlen, v.len);
                check("awburst", awburst, 2'b01);
                check("awsize", awsize, 3'd2);
                check("wstrb", wstrb, 4'hF);
                w_act = 1'b1;
            end
            if (arvalid && arready) begin
                ar_hs++;
                check("araddr", araddr, v.addr);
                check("arlen", arlen, v.len);
                check("arsize", arsize, 3'd2);
                r_act = 1'b1;
            end
            if (bvalid && bready) b_pend = 1'b0;
            if (wvalid && wready) begin
                check("wdata", wdata, 32'(wbeat + 1));
                check("wlast", wlast, (wbeat == int'(v.len)));
                if (wlast) begin
                    w_act  = 1'b0;
                    b_pend = 1'b1;
                end
                wbeat++;
            end
            if (rd_valid && rd_ready) begin
                exp_last = (rbeat == v.early_last) || (rbeat == int'(v.len));
                check("rd_data", rd_data, 32'hA0 + 32'(rbeat));
                check("rd_last", rd_last, exp_last);
                if (exp_last) r_act = 1'b0;
                rbeat++;
            end
            if (done) begin
                done_cnt++;
                got_err  = err;
                finished = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        check("done_seen", finished, 1);
        check("done_pulse_len", done, 0);
        check("cmd_ready_after_done", cmd_ready, 1);
        check("done_count", done_cnt, 1);
        check("err", got_err, v.exp_err);
        check("beats", v.wr ? wbeat : rbeat, v.exp_beats);
        check("addr_handshakes", v.wr ? aw_hs : ar_hs, v.exp_addr_hs);
        check("no_other_addr", v.wr ? ar_hs : aw_hs, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 32'h100,  8'd3,   -1, -1, 2'b00, 0, 1'b0, 4,   1};
        vecs[1] = '{1'b0, 32'h40,   8'd7,   -1, -1, 2'b00, 1, 1'b0, 8,   1};
        vecs[2] = '{1'b1, 32'h200,  8'd0,   -1, -1, 2'b00, 2, 1'b0, 1,   1};
        vecs[3] = '{1'b0, 32'h80,   8'd3,    1, -1, 2'b00, 0, 1'b1, 4,   1};
        vecs[4] = '{1'b1, 32'h300,  8'd1,   -1, -1, 2'b10, 0, 1'b1, 2,   1};
        vecs[5] = '{1'b0, 32'h0,    8'd3,   -1,  1, 2'b00, 0, 1'b1, 2,   1};
`ifdef AXI_BURST_MASTER_4K_CHECK_EN
        vecs[6] = '{1'b0, 32'hFF8,  8'd3,   -1, -1, 2'b00, 0, 1'b1, 0,   0};
`else
        vecs[6] = '{1'b0, 32'hFF8,  8'd3,   -1, -1, 2'b00, 0, 1'b0, 4,   1};
`endif
        vecs[7] = '{1'b1, 32'h0,    8'd255, -1, -1, 2'b00, 3, 1'b0, 256, 1};
        vecs[8] = '{1'b0, 32'h2000, 8'd2,   -1, -1, 2'b00, 3, 1'b0, 3,   1};

        // Reset state: everything quiet, cmd_ready held low.
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_rready", rready, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        #1;
        check("cmd_ready_after_rst", cmd_ready, 1);
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
            idle_inputs();
            tick();
        end

        // Reset during beat 2 of a write burst abandons it without a done pulse.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_len = 8'd3;
        awready = 1'b1; wready = 1'b1; wr_valid = 1'b1; wr_data = 32'd1;
        #1;
        check("mr_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        #1;
        check("mr_awvalid", awvalid, 1);
        tick();
        check("mr_beat1_wvalid", wvalid, 1);
        tick();
        wr_data = 32'd2;
        #1;
        check("mr_beat2_wvalid", wvalid, 1);
        check("mr_beat2_wlast", wlast, 0);
        reset = 1'b1;
        #1;
        check("mr_wvalid", wvalid, 0);
        check("mr_wr_ready", wr_ready, 0);
        check("mr_awvalid_rst", awvalid, 0);
        check("mr_arvalid_rst", arvalid, 0);
        check("mr_bready_rst", bready, 0);
        check("mr_cmd_ready_rst", cmd_ready, 0);
        check("mr_done_rst", done, 0);
        tick();
        tick();
        idle_inputs();
        reset = 1'b0;
        #1;
        check("mr_cmd_ready_release", cmd_ready, 1);
        check("mr_done_release", done, 0);
        tick();
        tick();
        check("mr_no_late_done", done, 0);

        // Normal operation resumes after the abandoned burst.
        run_vec(0);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
